regfile_access_controller: RTL and testbench

//  Command-driven initiator for the 4-entry N-bit register file: accepts WRITE/READ/COPY/SWAP

---
 rtl/regfile_access_controller.sv | 196 +++++++++++++++++++
 tb/tb_regfile_access_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_controller.sv
// Command-driven WRITE/READ/COPY/SWAP initiator for a 4-entry N-bit register file.
// Define RFC_READBACK_EN to add a VERIFY readback after every write-performing command.
module regfile_access_controller #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [1:0]   cmd_src,
  input  logic [1:0]   cmd_dst,
  input  logic [N-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err,
  output logic         WA0,
  output logic         WA1,
  output logic         WrEn,
  output logic [N-1:0] rf_din,
  output logic         RA0,
  output logic         RA1,
  input  logic [N-1:0] rf_dout
);

  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_COPY = 2'b10, OP_SWAP = 2'b11} op_e;

`ifdef RFC_READBACK_EN
  typedef enum logic [2:0] {IDLE, EXEC, SWAP1, SWAP2, VERIFY, RESP} state_e;
`else
  typedef enum logic [2:0] {IDLE, EXEC, SWAP1, SWAP2, RESP} state_e;
`endif

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [1:0]   src_q, src_d;
  logic [1:0]   dst_q, dst_d;
  logic [N-1:0] data_q, data_d;
  logic [N-1:0] tmp_q, tmp_d;
  logic [N-1:0] result_q, result_d;
  logic         rspValid_q, rspValid_d;
  logic [1:0]   waSel, raSel;
`ifdef RFC_READBACK_EN
  logic [N-1:0] lastWr_q, lastWr_d;
  logic         err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dst_d      = dst_q;
    data_d     = data_q;
    tmp_d      = tmp_q;
    result_d   = result_q;
    rspValid_d = 1'b0;
    waSel      = 2'b00;
    raSel      = 2'b00;
    WrEn       = 1'b0;
    rf_din     = '0;
    cmd_ready  = 1'b0;
`ifdef RFC_READBACK_EN
    lastWr_d   = lastWr_q;
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: begin
        // Ready is gated by reset so it reads low for the whole reset interval.
        cmd_ready = RST;
        if (cmd_valid && RST) begin
          op_d   = op_e'(cmd_op);
          src_d  = cmd_src;
          dst_d  = cmd_dst;
          data_d = cmd_data;
          state_d = (op_e'(cmd_op) == OP_SWAP) ? SWAP1 : EXEC;
`ifdef RFC_READBACK_EN
          err_d  = 1'b0;
`endif
        end
      end

      EXEC: begin
        case (op_q)
          OP_WRITE: begin
            waSel    = dst_q;
            rf_din   = data_q;
            WrEn     = 1'b1;
            result_d = data_q;
          end
          OP_READ: begin
            raSel    = src_q;
            result_d = rf_dout;
          end
          OP_COPY: begin
            raSel    = src_q;
            waSel    = dst_q;
            rf_din   = rf_dout;
            WrEn     = 1'b1;
            result_d = rf_dout;
          end
          OP_SWAP: begin
            waSel  = dst_q;
            rf_din = tmp_q;
            WrEn   = 1'b1;
          end
          default: ;
        endcase
`ifdef RFC_READBACK_EN
        lastWr_d = rf_din;
        state_d  = (op_q == OP_READ) ? RESP : VERIFY;
`else
        state_d  = RESP;
`endif
      end

      SWAP1: begin
        raSel   = src_q;
        tmp_d   = rf_dout;
        state_d = SWAP2;
      end

      SWAP2: begin
        // The response of a SWAP is the value landing in src, i.e. old dst.
        raSel    = dst_q;
        waSel    = src_q;
        rf_din   = rf_dout;
        WrEn     = 1'b1;
        result_d = rf_dout;
        state_d  = EXEC;
      end

`ifdef RFC_READBACK_EN
      VERIFY: begin
        raSel   = dst_q;
        err_d   = (rf_dout != lastWr_q);
        state_d = RESP;
      end
`endif

      RESP: begin
        // rsp_valid is registered, so it rises one cycle after RESP is entered.
        rspValid_d = !(rspValid_q && rsp_ready);
        if (rspValid_q && rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      op_q       <= OP_WRITE;
      src_q      <= 2'b00;
      dst_q      <= 2'b00;
      data_q     <= '0;
      tmp_q      <= '0;
      result_q   <= '0;
      rspValid_q <= 1'b0;
`ifdef RFC_READBACK_EN
      lastWr_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      data_q     <= data_d;
      tmp_q      <= tmp_d;
      result_q   <= result_d;
      rspValid_q <= rspValid_d;
`ifdef RFC_READBACK_EN
      lastWr_q   <= lastWr_d;
      err_q      <= err_d;
`endif
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_data  = result_q;
  assign WA0       = waSel[0];
  assign WA1       = waSel[1];
  assign RA0       = raSel[0];
  assign RA1       = raSel[1];
`ifdef RFC_READBACK_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_access_controller.sv
// Self-checking bench for regfile_access_controller with a behavioural 4x4 register file
// (optional stuck-at-zero entry) and a response scoreboard queue.
module tb_regfile_access_controller;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op, cmd_src, cmd_dst;
  logic [N-1:0] cmd_data;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [N-1:0] rsp_data;
  logic         WA0, WA1, WrEn, RA0, RA1;
  logic [N-1:0] rf_din, rf_dout;

  int total = 0;
  int bad   = 0;

  regfile_access_controller #(.N(N)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .WA0(WA0), .WA1(WA1), .WrEn(WrEn), .rf_din(rf_din),
    .RA0(RA0), .RA1(RA1), .rf_dout(rf_dout)
  );

  always #5 CLK = ~CLK;

  // Register file model; entry 3 can be made stuck at zero to provoke readback errors.
  logic [N-1:0] mem [4];
  logic         memClr;
  logic         stuckEn;
  logic [1:0]   wIdx, rIdx;
  assign wIdx = {WA1, WA0};
  assign rIdx = {RA1, RA0};
  assign rf_dout = (stuckEn && rIdx == 2'd3) ? '0 : mem[rIdx];

  always @(posedge CLK or posedge memClr) begin
    if (memClr) begin
      for (int k = 0; k < 4; k++) mem[k] <= '0;
    end else if (WrEn && !(stuckEn && wIdx == 2'd3)) begin
      mem[wIdx] <= rf_din;
    end
  end

  int         wrCount = 0;
  logic [1:0] lastWa  = 2'b00;
  always @(posedge CLK) begin
    if (WrEn) begin
      wrCount <= wrCount + 1;
      lastWa  <= wIdx;
    end
  end

  typedef struct {
    logic [N-1:0] data;
    logic         err;
  } rsp_t;
  rsp_t sbQ[$];

  typedef struct {
    logic [1:0]   op;
    logic [1:0]   src;
    logic [1:0]   dst;
    logic [N-1:0] data;
    logic [N-1:0] expData;
    int           hold;
  } vec_t;
  vec_t vecs[15];

`ifdef RFC_READBACK_EN
  localparam logic stuckErr = 1'b1;
`else
  localparam logic stuckErr = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int expLatency(input logic [1:0] op);
    int l;
    l = (op == 2'b11) ? 4 : 2;
`ifdef RFC_READBACK_EN
    if (op != 2'b01) l = l + 1;
`endif
    return l;
  endfunction

  function automatic int expWrites(input logic [1:0] op);
    case (op)
      2'b00, 2'b10: return 1;
      2'b11:        return 2;
      default:      return 0;
    endcase
  endfunction

  // Issues one command, checks latency/hold/response/write pulses, scoreboards the response.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                               input logic [N-1:0] data, input logic [N-1:0] expData,
                               input logic expErr, input int hold);
    int   lat;
    int   wrBefore;
    rsp_t r;
    @(negedge CLK);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_data = data; cmd_valid = 1'b1;
    checkOutput("cmd_ready idle", cmd_ready, 1);
    wrBefore = wrCount;
    @(posedge CLK);
    sbQ.push_back('{expData, expErr});
    @(negedge CLK);
    cmd_valid = 1'b0;
    checkOutput("cmd_ready busy", cmd_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 30) begin
      @(negedge CLK);
      lat++;
    end
    checkOutput("latency", lat, expLatency(op));
    for (int i = 0; i < hold; i++) begin
      checkOutput("held rsp_valid", rsp_valid, 1);
      checkOutput("held rsp_data", rsp_data, expData);
      checkOutput("held cmd_ready", cmd_ready, 0);
      @(negedge CLK);
    end
    rsp_ready = 1'b1;
    r = sbQ.pop_front();
    checkOutput("rsp_data", rsp_data, r.data);
    checkOutput("rsp_err", rsp_err, r.err);
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid drop", rsp_valid, 0);
    checkOutput("cmd_ready after rsp", cmd_ready, 1);
    checkOutput("wren pulses", wrCount - wrBefore, expWrites(op));
    if (op != 2'b01) checkOutput("write addr", lastWa, dst);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // op, src, dst, data, expected rsp_data, rsp_ready hold cycles
    vecs[0]  = '{2'b00, 2'd0, 2'd2, 4'hA, 4'hA, 0};
    vecs[1]  = '{2'b01, 2'd2, 2'd0, 4'h0, 4'hA, 0};
    vecs[2]  = '{2'b00, 2'd0, 2'd0, 4'h3, 4'h3, 0};
    vecs[3]  = '{2'b00, 2'd0, 2'd1, 4'h5, 4'h5, 1};
    vecs[4]  = '{2'b11, 2'd0, 2'd1, 4'h0, 4'h5, 0};
    vecs[5]  = '{2'b01, 2'd0, 2'd0, 4'h0, 4'h5, 0};
    vecs[6]  = '{2'b01, 2'd1, 2'd0, 4'h0, 4'h3, 0};
    vecs[7]  = '{2'b10, 2'd1, 2'd3, 4'h9, 4'h3, 5};
    vecs[8]  = '{2'b01, 2'd3, 2'd0, 4'h0, 4'h3, 0};
    vecs[9]  = '{2'b00, 2'd0, 2'd2, 4'h7, 4'h7, 0};
    vecs[10] = '{2'b11, 2'd2, 2'd2, 4'h0, 4'h7, 0};
    vecs[11] = '{2'b01, 2'd2, 2'd1, 4'h0, 4'h7, 0};
    vecs[12] = '{2'b10, 2'd0, 2'd0, 4'h0, 4'h5, 0};
    vecs[13] = '{2'b00, 2'd1, 2'd3, 4'hF, 4'hF, 0};
    vecs[14] = '{2'b01, 2'd3, 2'd2, 4'h0, 4'hF, 2};

    RST = 1'b1; memClr = 1'b1; stuckEn = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 2'b00; cmd_dst = 2'b00; cmd_data = '0;
    rsp_ready = 1'b0;
    #2 RST = 1'b0;
    #1;
    checkOutput("reset cmd_ready", cmd_ready, 0);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset rsp_data", rsp_data, 0);
    checkOutput("reset rsp_err", rsp_err, 0);
    checkOutput("reset WrEn", WrEn, 0);
    checkOutput("reset rf_din", rf_din, 0);
    checkOutput("reset addr", {WA1, WA0, RA1, RA0}, 0);
    repeat (3) @(negedge CLK);
    memClr = 1'b0;
    RST = 1'b1;
    #1 checkOutput("cmd_ready after reset", cmd_ready, 1);

    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].data, vecs[v].expData, 1'b0, vecs[v].hold);
    end
    checkOutput("mem0", mem[0], 4'h5);
    checkOutput("mem1", mem[1], 4'h3);
    checkOutput("mem2", mem[2], 4'h7);
    checkOutput("mem3", mem[3], 4'hF);

    // Reset asserted while SWAP2 drives its write: the write must be cancelled.
    @(negedge CLK);
    cmd_op = 2'b11; cmd_src = 2'd0; cmd_dst = 2'd1; cmd_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("swap2 WrEn", WrEn, 1);
    #1 RST = 1'b0;
    #1;
    checkOutput("midswap WrEn", WrEn, 0);
    checkOutput("midswap rsp_valid", rsp_valid, 0);
    checkOutput("midswap cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("post reset cmd_ready", cmd_ready, 1);
    checkOutput("midswap mem0", mem[0], 4'h5);
    checkOutput("midswap mem1", mem[1], 4'h3);

    stuckEn = 1'b1;
    applyStimulus(2'b00, 2'd0, 2'd3, 4'hF, 4'hF, stuckErr, 0);
    stuckEn = 1'b0;
    applyStimulus(2'b00, 2'd0, 2'd0, 4'h9, 4'h9, 1'b0, 0);
    applyStimulus(2'b01, 2'd0, 2'd1, 4'h0, 4'h9, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
